// File: rtl/alu_stage.sv
// alu_stage: 16-bit COMET2-style ALU stage with a valid/ready handshake on
// both sides.
// Arithmetic and logic ops finish in one cycle. Shift ops move one bit
// position per cycle, and the shift count is capped at 17.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   high only in IDLE while rst is low
//   op         operation code (0-10 legal, 11-15 illegal)
//   a          first operand
//   b          second operand, or the shift count for shift ops
//   out_valid  result and flags valid; held until out_ready
//   out_ready  consumer accepts the result
//   result     16-bit result
//   of/sf/zf   overflow, sign and zero flags
//   err        illegal opcode
module alu_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        of,
   output logic        sf,
   output logic        zf,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      r_state;
   logic [15:0] r_work;
   logic [4:0]  r_cnt;
   logic [3:0]  r_op;
   logic        r_of, r_sf, r_zf, r_err;

   state_e      w_state_nxt;
   logic [15:0] w_work_nxt;
   logic [4:0]  w_cnt_nxt;
   logic [3:0]  w_op_nxt;
   logic        w_of_nxt, w_sf_nxt, w_zf_nxt, w_err_nxt;

   logic [16:0] w_sum, w_diff;
   logic [15:0] w_alu_res;
   logic        w_alu_of;
   logic [4:0]  w_n;
   logic [15:0] w_shift_val;
   logic        w_shift_out;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} + {1'b0, ~b} + 17'd1;
   assign w_n    = (b > 16'd17) ? 5'd17 : b[4:0];

   // Single-cycle ops 0-6.
   always_comb begin
      w_alu_res = 16'h0000;
      w_alu_of  = 1'b0;
      case (op)
         4'd0: begin
            w_alu_res = w_sum[15:0];
            w_alu_of  = (a[15] == b[15]) && (w_sum[15] != a[15]);
         end
         4'd1: begin
            w_alu_res = w_sum[15:0];
            w_alu_of  = w_sum[16];
         end
         4'd2: begin
            w_alu_res = w_diff[15:0];
            w_alu_of  = (a[15] != b[15]) && (w_diff[15] != a[15]);
         end
         4'd3: begin
            w_alu_res = w_diff[15:0];
            w_alu_of  = ~w_diff[16];  // no carry out means a borrow (a < b)
         end
         4'd4: w_alu_res = a & b;
         4'd5: w_alu_res = a | b;
         4'd6: w_alu_res = a ^ b;
         default: ;
      endcase
   end

   // One bit-step of the latched shift op on the working register.
   always_comb begin
      w_shift_val = r_work;
      w_shift_out = 1'b0;
      case (r_op)
         4'd7: begin
            w_shift_val = {r_work[15], r_work[13:0], 1'b0};
            w_shift_out = r_work[14];
         end
         4'd8: begin
            w_shift_val = {r_work[15], r_work[15:1]};
            w_shift_out = r_work[0];
         end
         4'd9: begin
            w_shift_val = {r_work[14:0], 1'b0};
            w_shift_out = r_work[15];
         end
         4'd10: begin
            w_shift_val = {1'b0, r_work[15:1]};
            w_shift_out = r_work[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      w_of_nxt    = r_of;
      w_sf_nxt    = r_sf;
      w_zf_nxt    = r_zf;
      w_err_nxt   = r_err;
      case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_op_nxt  = op;
               w_err_nxt = 1'b0;
               if (op <= 4'd6) begin
                  w_work_nxt  = w_alu_res;
                  w_of_nxt    = w_alu_of;
                  w_sf_nxt    = w_alu_res[15];
                  w_zf_nxt    = (w_alu_res == 16'h0000);
                  w_state_nxt = StDone;
               end else if (op <= 4'd10) begin
                  // Flags preset for the n = 0 case; SHIFT overwrites them.
                  w_work_nxt  = a;
                  w_cnt_nxt   = w_n;
                  w_of_nxt    = 1'b0;
                  w_sf_nxt    = a[15];
                  w_zf_nxt    = (a == 16'h0000);
                  w_state_nxt = (w_n == 5'd0) ? StDone : StShift;
               end else begin
                  w_work_nxt  = 16'h0000;
                  w_of_nxt    = 1'b0;
                  w_sf_nxt    = 1'b0;
                  w_zf_nxt    = 1'b0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = StDone;
               end
            end
         end
         StShift: begin
            w_work_nxt = w_shift_val;
            w_of_nxt   = w_shift_out;
            w_sf_nxt   = w_shift_val[15];
            w_zf_nxt   = (w_shift_val == 16'h0000);
            w_cnt_nxt  = r_cnt - 5'd1;
            if (r_cnt == 5'd1) w_state_nxt = StDone;
         end
         StDone: begin
            if (out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_work  <= 16'h0000;
         r_cnt   <= 5'd0;
         r_op    <= 4'd0;
         r_of    <= 1'b0;
         r_sf    <= 1'b0;
         r_zf    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_of    <= w_of_nxt;
         r_sf    <= w_sf_nxt;
         r_zf    <= w_zf_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign in_ready  = (r_state == StIdle) && !rst;
   assign out_valid = (r_state == StDone);
   assign result    = r_work;
   assign of        = r_of;
   assign sf        = r_sf;
   assign zf        = r_zf;
   assign err       = r_err;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: self-checking bench for alu_stage.
// It runs directed corner cases, then randomized ops. Every result is checked
// against an arithmetic reference model kept inside this bench.
module tb_alu_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [15:0] a, b, result;
   logic        of, sf, zf, err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        of;
      logic        sf;
      logic        zf;
      logic        err;
      logic [5:0]  lat;
   } exp_t;

   alu_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .of        (of),
      .sf        (sf),
      .zf        (zf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic and wide shifts.
   function automatic exp_t model(input logic [3:0] mop, input logic [15:0] ma,
                                  input logic [15:0] mb);
      exp_t e;
      int   n, sa, sb, t;
      logic [63:0] x;
      logic signed [31:0] s;
      e = '0;
      n = (mb > 16'd17) ? 17 : int'(mb);
      sa = $signed(ma);
      sb = $signed(mb);
      e.lat = 6'd1;
      case (mop)
         4'd0: begin
            t = sa + sb; e.res = ma + mb; e.of = (t > 32767) || (t < -32768);
         end
         4'd1: begin
            e.res = ma + mb; e.of = (int'(ma) + int'(mb)) > 65535;
         end
         4'd2: begin
            t = sa - sb; e.res = ma - mb; e.of = (t > 32767) || (t < -32768);
         end
         4'd3: begin
            e.res = ma - mb; e.of = ma < mb;
         end
         4'd4: e.res = ma & mb;
         4'd5: e.res = ma | mb;
         4'd6: e.res = ma ^ mb;
         4'd7: begin
            x = 64'(ma[14:0]) << n;
            e.res = {ma[15], x[14:0]}; e.of = x[15]; e.lat = 6'(n + 1);
         end
         4'd8: begin
            s = {ma, 16'h0000};
            s = s >>> n;
            e.res = s[31:16]; e.of = s[15]; e.lat = 6'(n + 1);
         end
         4'd9: begin
            x = 64'(ma) << n;
            e.res = x[15:0]; e.of = x[16]; e.lat = 6'(n + 1);
         end
         4'd10: begin
            x = {32'h0, ma, 16'h0000} >> n;
            e.res = x[31:16]; e.of = x[15]; e.lat = 6'(n + 1);
         end
         default: e.err = 1'b1;
      endcase
      if (!e.err) begin
         e.sf = e.res[15];
         e.zf = (e.res == 16'h0000);
      end
      return e;
   endfunction

   // Issue one op, measure latency, hold back-pressure, then release it.
   task automatic run_op(input logic [3:0] top, input logic [15:0] ta, input logic [15:0] tb_v,
                         input int hold, input string tag);
      exp_t e;
      int   lat;
      e = model(top, ta, tb_v);
      in_valid = 1'b1; op = top; a = ta; b = tb_v;
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      // Inputs scrambled while busy must not disturb the op in flight.
      in_valid = 1'($urandom); op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(e.lat));
      check({tag, ".result"}, 32'(result), 32'(e.res));
      check({tag, ".flags"}, {28'h0, of, sf, zf, err}, {28'h0, e.of, e.sf, e.zf, e.err});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold"}, {15'h0, out_valid, in_ready, result, of, sf, zf, err},
               {15'h0, 1'b1, 1'b0, e.res, e.of, e.sf, e.zf, e.err});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check({tag, ".release"}, {30'h0, out_valid, in_ready}, {30'h0, 1'b0, 1'b1});
   endtask

   initial begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.outs", {11'h0, out_valid, in_ready, result, of, sf, zf, err}, 32'h0);
      rst = 1'b0; #1;
      check("reset.in_ready", 32'(in_ready), 32'd1);

      run_op(4'd0,  16'h7FFF, 16'h0001, 0, "adda_ovf");
      run_op(4'd1,  16'hFFFF, 16'h0001, 0, "addl_carry");
      run_op(4'd2,  16'h8000, 16'h0001, 0, "suba_ovf");
      run_op(4'd3,  16'h0000, 16'h0001, 0, "subl_borrow");
      run_op(4'd6,  16'h5A5A, 16'h5A5A, 0, "xor_zero");
      run_op(4'd8,  16'h8001, 16'h0001, 0, "sra_1");
      run_op(4'd7,  16'h4000, 16'h0001, 0, "sla_1");
      run_op(4'd9,  16'h0001, 16'd16,   0, "sll_16");
      run_op(4'd10, 16'hFFFF, 16'h0100, 0, "srl_cap");
      run_op(4'd9,  16'hA5C3, 16'h0000, 0, "sll_0");
      run_op(4'd5,  16'h1234, 16'h4321, 5, "or_backpressure");
      run_op(4'd13, 16'h1234, 16'h5678, 0, "illegal_13");
      run_op(4'd4,  16'hF0F0, 16'hFF00, 0, "and_after_err");

      // Reset in the middle of a shift.
      in_valid = 1'b1; op = 4'd10; a = 16'hBEEF; b = 16'd10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midreset.outs", {11'h0, out_valid, in_ready, result, of, sf, zf, err}, 32'h0);
      rst = 1'b0; #1;
      check("midreset.in_ready", 32'(in_ready), 32'd1);
      run_op(4'd0, 16'h0001, 16'h0001, 0, "adda_after_reset");

      for (int k = 0; k < 60; k++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         run_op(rop, ra, rb, $urandom_range(0, 3), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
